// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 round sequencer.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SB,
        ST_SR,
        ST_MC,
        ST_ARK,
        ST_CAP,
        ST_DONE
    } state_t;

    localparam int XOR_LEN_DEF = 18;
    localparam int SB_LEN_DEF  = 17;
    localparam int SR_LEN_DEF  = 30;
    localparam int MC_LEN_DEF  = 21;
    localparam int ARK_LEN_DEF = 17;
    localparam int CAP_DLY_DEF = 1;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Round constant for rounds 1..10; zero outside that range.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Byte idx of a 128-bit vector; byte 0 is the most significant.
    function automatic logic [7:0] get_byte(input logic [127:0] vec, input logic [3:0] idx);
        logic [127:0] sh;
        sh = vec << {idx, 3'b000};
        return sh[127:120];
    endfunction

endpackage

// File: rtl/aes_round_sequencer_key_step.sv
// SubWord(RotWord(w)) ^ Rcon for on-the-fly AES-128 key expansion.
// The S-box is computed as GF(2^8) inversion followed by the affine map.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [31:0] prev_word,
    input  logic [3:0]  round,
    output logic [31:0] step_word
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] rot;

    // Rotate, substitute each byte, fold in the round constant
    always_comb begin
        rot       = {prev_word[23:0], prev_word[31:24]};
        step_word = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                    ^ {rcon(round), 24'h000000};
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Job-level controller for the byte-serial AES-128 encrypt core.
//
// state | meaning
// IDLE  | waiting for a job; start_ready high
// INIT  | stream plaintext and cipher key bytes for the initial AddRoundKey
// SB    | SubBytes; next round key is expanded here at pc 0..3
// SR    | ShiftRows; skips MC in the final round
// MC    | MixColumns
// ARK   | stream round-key bytes for the round AddRoundKey
// CAP   | settle delay before capturing the core message
// DONE  | hold ciphertext until the consumer accepts it
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int XOR_LEN = aes_pkg::XOR_LEN_DEF,
    parameter int SB_LEN  = aes_pkg::SB_LEN_DEF,
    parameter int SR_LEN  = aes_pkg::SR_LEN_DEF,
    parameter int MC_LEN  = aes_pkg::MC_LEN_DEF,
    parameter int ARK_LEN = aes_pkg::ARK_LEN_DEF,
    parameter int CAP_DLY = aes_pkg::CAP_DLY_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         core_enable,
    output logic [7:0]   core_in,
    output logic [7:0]   core_key,
    input  logic [127:0] core_msg,
    output logic [127:0] ct,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic         busy,
    output logic [3:0]   round
);

    state_t       state_q;
    state_t       state_d;
    logic [7:0]   pc_q;
    logic [7:0]   phase_len;
    logic         phase_end;
    logic [127:0] pt_q;
    logic [127:0] rk_q;
    logic [127:0] ct_q;
    logic         ct_valid_q;
    logic [3:0]   round_q;
    logic [31:0]  step_word;
    logic         accept;

    assign accept = start_valid && (state_q == ST_IDLE);

    aes_key_step u_key_step (
        .prev_word (rk_q[31:0]),
        .round     (round_q),
        .step_word (step_word)
    );

    // Length of the phase the sequencer is currently in
    always_comb begin
        phase_len = 8'd1;
        case (state_q)
            ST_INIT: phase_len = 8'(XOR_LEN);
            ST_SB:   phase_len = 8'(SB_LEN);
            ST_SR:   phase_len = 8'(SR_LEN);
            ST_MC:   phase_len = 8'(MC_LEN);
            ST_ARK:  phase_len = 8'(ARK_LEN);
            ST_CAP:  phase_len = 8'(CAP_DLY);
            default: phase_len = 8'd1;
        endcase
    end

    assign phase_end = (pc_q == phase_len - 8'd1);

    // Next state and the byte stream driven into the core
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        busy        = 1'b1;
        core_enable = 1'b0;
        core_in     = 8'h00;
        core_key    = 8'h00;
        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) state_d = ST_INIT;
            end
            ST_INIT: begin
                core_enable = 1'b1;
                if (pc_q < 8'd16) begin
                    core_in  = get_byte(pt_q, pc_q[3:0]);
                    core_key = get_byte(rk_q, pc_q[3:0]);
                end
                if (phase_end) state_d = ST_SB;
            end
            ST_SB: begin
                core_enable = 1'b1;
                if (phase_end) state_d = ST_SR;
            end
            ST_SR: begin
                core_enable = 1'b1;
                if (phase_end) state_d = (round_q == LAST_ROUND) ? ST_ARK : ST_MC;
            end
            ST_MC: begin
                core_enable = 1'b1;
                if (phase_end) state_d = ST_ARK;
            end
            ST_ARK: begin
                core_enable = 1'b1;
                if (pc_q < 8'd16) core_key = get_byte(rk_q, pc_q[3:0]);
                if (phase_end) state_d = (round_q == LAST_ROUND) ? ST_CAP : ST_SB;
            end
            ST_CAP: begin
                core_enable = 1'b1;
                if (phase_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (ct_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and per-phase cycle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                pc_q <= 8'd0;
            end else if (state_q != ST_IDLE && state_q != ST_DONE) begin
                pc_q <= pc_q + 8'd1;
            end
        end
    end

    // Job operands, round counter and one-word-per-cycle key expansion
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pt_q    <= '0;
            rk_q    <= '0;
            round_q <= 4'd0;
        end else begin
            if (accept) begin
                pt_q    <= pt;
                rk_q    <= key;
                round_q <= 4'd0;
            end
            if (state_q == ST_INIT && phase_end) round_q <= 4'd1;
            if (state_q == ST_ARK && phase_end && round_q != LAST_ROUND) round_q <= round_q + 4'd1;
            if (state_q == ST_SB && pc_q < 8'd4) begin
                case (pc_q[1:0])
                    2'd0: rk_q[127:96] <= rk_q[127:96] ^ step_word;
                    2'd1: rk_q[95:64]  <= rk_q[95:64]  ^ rk_q[127:96];
                    2'd2: rk_q[63:32]  <= rk_q[63:32]  ^ rk_q[95:64];
                    default: rk_q[31:0] <= rk_q[31:0]  ^ rk_q[63:32];
                endcase
            end
        end
    end

    // Ciphertext capture and consumer hand-off
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ct_q       <= '0;
            ct_valid_q <= 1'b0;
        end else if (state_q == ST_CAP && phase_end) begin
            ct_q       <= core_msg;
            ct_valid_q <= 1'b1;
        end else if (state_q == ST_DONE && ct_ready) begin
            ct_valid_q <= 1'b0;
        end
    end

    assign ct       = ct_q;
    assign ct_valid = ct_valid_q;
    assign round    = round_q;

endmodule
